// File: rtl/mc_frame_gate.sv
// mc_frame_gate: store-and-forward frame buffer that asks a multicast controller
// for a destination port per frame, then forwards or drops the frame.
// state | meaning
// IDLE  | no committed frame pending
// CATCH | io_catch pulse to controller
// WAIT1 | controller working, prefetch first byte
// WAIT2 | latch ctrl into out_port, choose SEND or DRAIN
// SEND  | stream frame bytes to output
// DRAIN | discard frame bytes, one per cycle
module mc_frame_gate #(
    parameter int AW = 11,
    parameter int DW = 8
) (
    input  logic          io_clk,
    input  logic          io_rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          in_ready,
    output logic          io_catch,
    input  logic [5:0]    ctrl,
    input  logic [5:0]    portNo,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic [5:0]    out_port,
    input  logic          out_ready,
    output logic [15:0]   drop_cnt
);
    typedef enum logic [2:0] {S_IDLE, S_CATCH, S_WAIT1, S_WAIT2, S_SEND, S_DRAIN} state_t;

    localparam logic [AW:0] ONE = 1;

    // Each entry carries the in_last flag so the read side finds frame ends itself.
    logic [DW:0]    mem_q [0:(1<<AW)-1];

    state_t         state_q, state_d;
    logic [AW:0]    wr_ptr_q, wr_ptr_d, start_q, start_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]    frame_cnt_q, frame_cnt_d, used;
    logic           discard_q, discard_d;
    logic [15:0]    drop_q, drop_d;
    logic [16:0]    drop_sum;
    logic [5:0]     port_q, port_d;
    logic [DW-1:0]  head_data_q;
    logic           head_last_q;
    logic [AW-1:0]  rd_addr;
    logic           in_fire, out_fire, full, wr_en, commit, done, head_load;
    logic           wr_drop, rd_drop;

    assign in_ready  = !io_rst;
    assign in_fire   = in_valid && in_ready;
    assign used      = wr_ptr_q - rd_ptr_q;
    assign full      = used[AW];

    assign io_catch  = (state_q == S_CATCH) && !io_rst;
    assign out_valid = (state_q == S_SEND) && !io_rst;
    assign out_fire  = out_valid && out_ready;
    assign out_data  = io_rst ? '0 : head_data_q;
    assign out_last  = out_valid && head_last_q;
    assign out_port  = io_rst ? '0 : port_q;
    assign drop_cnt  = drop_q;

    always_comb begin
        wr_en     = 1'b0;
        commit    = 1'b0;
        wr_drop   = 1'b0;
        wr_ptr_d  = wr_ptr_q;
        start_d   = start_q;
        discard_d = discard_q;
        if (in_fire) begin
            if (discard_q) begin
                if (in_last) discard_d = 1'b0;
            end else if (full) begin
                // Roll back the partial frame; the rest of it is swallowed.
                wr_ptr_d  = start_q;
                wr_drop   = 1'b1;
                discard_d = !in_last;
            end else begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + ONE;
                if (in_last) begin
                    commit  = 1'b1;
                    start_d = wr_ptr_q + ONE;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        port_d    = port_q;
        rd_ptr_d  = rd_ptr_q;
        rd_addr   = rd_ptr_q[AW-1:0];
        head_load = 1'b0;
        done      = 1'b0;
        rd_drop   = 1'b0;
        case (state_q)
            S_IDLE:  if (frame_cnt_q != '0) state_d = S_CATCH;
            S_CATCH: state_d = S_WAIT1;
            S_WAIT1: begin
                head_load = 1'b1;
                state_d   = S_WAIT2;
            end
            S_WAIT2: begin
                head_load = 1'b1;
                port_d    = ctrl;
                state_d   = (ctrl == '0 || ctrl > portNo) ? S_DRAIN : S_SEND;
            end
            S_SEND: begin
                if (out_fire) begin
                    head_load = 1'b1;
                    rd_addr   = AW'(rd_ptr_q + ONE);
                    rd_ptr_d  = rd_ptr_q + ONE;
                    if (head_last_q) begin
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                head_load = 1'b1;
                rd_addr   = AW'(rd_ptr_q + ONE);
                rd_ptr_d  = rd_ptr_q + ONE;
                if (head_last_q) begin
                    done    = 1'b1;
                    rd_drop = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (commit && !done)      frame_cnt_d = frame_cnt_q + ONE;
        else if (!commit && done) frame_cnt_d = frame_cnt_q - ONE;
        // Write-side and read-side drops can land in the same cycle.
        drop_sum = {1'b0, drop_q} + 17'(wr_drop) + 17'(rd_drop);
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge io_clk) begin
        if (io_rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            start_q     <= '0;
            rd_ptr_q    <= '0;
            frame_cnt_q <= '0;
            discard_q   <= 1'b0;
            drop_q      <= '0;
            port_q      <= '0;
            head_data_q <= '0;
            head_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            start_q     <= start_d;
            rd_ptr_q    <= rd_ptr_d;
            frame_cnt_q <= frame_cnt_d;
            discard_q   <= discard_d;
            drop_q      <= drop_d;
            port_q      <= port_d;
            if (head_load) {head_last_q, head_data_q} <= mem_q[rd_addr];
        end
    end

    always_ff @(posedge io_clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= {in_last, in_data};
    end
endmodule

// File: doc/mc_frame_gate.md
MC_FRAME_GATE -- requirements
Module: mc_frame_gate

Interface
REQ-001 The block SHALL have one clock, io_clk; reset io_rst is synchronous and active-high.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- AW, 11, byte-buffer address width (depth 2^AW bytes)
- DW, 8, data width
REQ-003 The block SHALL have these ports (name  direction  width  meaning):
- io_clk  in  1  clock
- io_rst  in  1  sync reset, active-high
- in_valid  in  1  input byte valid
- in_data  in  DW  input byte
- in_last  in  1  last byte of frame
- in_ready  out  1  input accept
- io_catch  out  1  frame-pending pulse to multicast controller
- ctrl  in  6  port select from controller (0 = none, 1..portNo)
- portNo  in  6  number of active ports
- out_valid  out  1  output byte valid
- out_data  out  DW  output byte
- out_last  out  1  last byte of frame
- out_port  out  6  destination port of current frame
- out_ready  in  1  output accept
- drop_cnt  out  16  dropped-frame counter, saturating

Function
REQ-004 Transfers SHALL occur when valid && ready on both streams; out_data, out_last and out_port SHALL hold stable while out_valid && !out_ready.
REQ-005 Write side SHALL be store-and-forward: bytes go to a 2^AW circular buffer, and a frame is committed (frame_cnt+1) in the cycle after its in_last is accepted.
REQ-006 in_ready SHALL be 1 except during reset; the block never back-pressures input.
REQ-007 If the buffer fills before in_last, the write side SHALL enter DISCARD: write pointer restored to frame start, remaining bytes up to and including in_last accepted and discarded, drop_cnt+1.
REQ-008 Read FSM states: IDLE, CATCH, WAIT1, WAIT2, SEND, DRAIN.
REQ-009 IDLE->CATCH when frame_cnt>0; CATCH->WAIT1->WAIT2 unconditionally; io_catch SHALL be 1 only in CATCH (exactly one cycle per frame).
REQ-010 In WAIT2 the block SHALL latch ctrl into out_port; if latched value is 0 or >portNo, next state SHALL be DRAIN, else SEND.
REQ-011 Latency: in_last accepted at cycle T with buffer previously empty -> io_catch high at T+2, ctrl sampled at T+4, out_valid high at T+5 with first byte on out_data.
REQ-012 SEND SHALL emit the frame bytes in order; on accepted out_last, frame_cnt-1 and FSM->IDLE.
REQ-013 DRAIN SHALL discard one byte per cycle without asserting out_valid, increment drop_cnt at the last byte, decrement frame_cnt and return to IDLE.
REQ-014 Commit and frame completion in the same cycle SHALL leave frame_cnt unchanged.
REQ-015 Consecutive io_catch pulses SHALL be separated by at least 3 cycles, so the controller always completes its repeat-count step.
REQ-016 Buffer pointers SHALL wrap modulo 2^AW; a frame may straddle the wrap point.
REQ-017 drop_cnt SHALL saturate at 0xFFFF.
REQ-018 Read RAM latency of 1 cycle SHALL be hidden by prefetch during WAIT1/WAIT2; SEND SHALL sustain 1 byte/cycle with out_ready=1.

Reset
REQ-019 When io_rst=1 at a clock edge, the block SHALL clear pointers, frame_cnt, DISCARD flag and drop_cnt, and set FSM=IDLE.
REQ-020 Outputs during reset SHALL be in_ready=0, io_catch=0, out_valid=0, out_last=0, out_port=0, out_data=0.
REQ-021 Reset mid-frame on either side SHALL silently lose buffered and partial frames with no drop_cnt change.

Verification
REQ-022 4-byte frame 0xA0..0xA3, ctrl=3 returned, portNo=4, out_ready=1 -> io_catch at T+2; out bytes A0..A3 at T+5..T+8, out_port=3, out_last at T+8.
REQ-023 Frame with ctrl=0 at WAIT2 -> no out_valid, drop_cnt 0->1, FSM back in IDLE.
REQ-024 AW=4, 20-byte frame -> DISCARD; all 20 bytes accepted, drop_cnt=1; a following 3-byte frame is delivered intact.
REQ-025 Three back-to-back frames, out_ready toggling 1/0 every cycle -> three io_catch pulses >=3 cycles apart, all bytes in order, data stable during stalls.
REQ-026 io_rst asserted during SEND byte 2 of 6 -> next cycle out_valid=0, frame_cnt=0; a new frame after reset is delivered normally.
REQ-027 Frame written across pointer wrap (start address 2^AW-2, 5 bytes) -> delivered byte-exact.
